// File: rtl/delay_timer_bank_if.sv
// Control/status bundle for delay_timer_bank: per-channel strobes and config in,
// per-channel busy/done out. The master drives the strobes, the timer bank is the slave.
interface delay_timer_bank_if #(
  parameter int NUM_CH = 4,
  parameter int DUR_W  = 11
);
  logic [NUM_CH-1:0]       start;
  logic [NUM_CH-1:0]       abort;
  logic [NUM_CH-1:0]       periodic;
  logic [NUM_CH*DUR_W-1:0] duration;
  logic [NUM_CH-1:0]       busy;
  logic [NUM_CH-1:0]       done;
  logic                    any_done;

  modport master (
    output start, abort, periodic, duration,
    input  busy, done, any_done
  );

  modport slave (
    input  start, abort, periodic, duration,
    output busy, done, any_done
  );
endinterface

// File: rtl/delay_timer_bank.sv
// Bank of NUM_CH independent millisecond delay timers with one-shot/periodic mode,
// abort, retrigger and a registered 1-cycle done pulse per expiry.
module delay_timer_bank #(
  parameter int NUM_CH        = 4,
  parameter int DUR_W         = 11,
  parameter int CYCLES_PER_MS = 250000
) (
  input  logic              clock,
  input  logic              reset,
  delay_timer_bank_if.slave bus
);
  localparam int TICK_W = (CYCLES_PER_MS > 2) ? $clog2(CYCLES_PER_MS) : 1;
  localparam logic [TICK_W-1:0] TICK_MAX = TICK_W'(CYCLES_PER_MS - 1);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [NUM_CH-1:0] w_busy;
  logic [NUM_CH-1:0] w_done;
  logic [NUM_CH-1:0] w_done_nxt_all;
  logic              r_any_done;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic [0:0]        r_state, w_state_nxt;
    logic [TICK_W-1:0] r_tick,  w_tick_nxt;
    logic [DUR_W-1:0]  r_ms,    w_ms_nxt;
    logic [DUR_W-1:0]  r_dur,   w_dur_nxt;
    logic              r_mode,  w_mode_nxt;
    logic              r_done,  w_done_nxt;
    logic [DUR_W-1:0]  w_dur_in;

    assign w_dur_in = bus.duration[g*DUR_W +: DUR_W];

    always_comb begin
      // NOTE: every output of this block gets a default first so no path infers a latch.
      w_state_nxt = r_state;
      w_tick_nxt  = r_tick;
      w_ms_nxt    = r_ms;
      w_dur_nxt   = r_dur;
      w_mode_nxt  = r_mode;
      w_done_nxt  = 1'b0;

      // Priority: abort, then start/retrigger, then normal counting.
      if (bus.abort[g]) begin
        w_state_nxt = ST_IDLE;
      end else if (bus.start[g]) begin
        w_dur_nxt  = w_dur_in;
        w_mode_nxt = bus.periodic[g];
        w_tick_nxt = TICK_MAX;
        if (w_dur_in == '0) begin
          w_ms_nxt    = '0;
          w_state_nxt = ST_IDLE;
          w_done_nxt  = 1'b1;
        end else begin
          w_ms_nxt    = w_dur_in - 1'b1;
          w_state_nxt = ST_RUN;
        end
      end else if (r_state == ST_RUN) begin
        if (r_tick != '0) begin
          w_tick_nxt = r_tick - 1'b1;
        end else if (r_ms != '0) begin
          w_ms_nxt   = r_ms - 1'b1;
          w_tick_nxt = TICK_MAX;
        end else begin
          w_done_nxt = 1'b1;
          if (r_mode) begin
            w_tick_nxt = TICK_MAX;
            w_ms_nxt   = r_dur - 1'b1;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
      end
    end

    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        r_state <= ST_IDLE;
        r_tick  <= '0;
        r_ms    <= '0;
        r_dur   <= '0;
        r_mode  <= 1'b0;
        r_done  <= 1'b0;
      end else begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        r_state <= w_state_nxt;
        r_tick  <= w_tick_nxt;
        r_ms    <= w_ms_nxt;
        r_dur   <= w_dur_nxt;
        r_mode  <= w_mode_nxt;
        r_done  <= w_done_nxt;
      end
    end

    assign w_busy[g]         = (r_state == ST_RUN);
    assign w_done[g]         = r_done;
    assign w_done_nxt_all[g] = w_done_nxt;
  end

  // any_done is registered from the same next-state terms so it aligns with done.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_any_done <= 1'b0;
    else       r_any_done <= |w_done_nxt_all;
  end

  assign bus.busy     = w_busy;
  assign bus.done     = w_done;
  assign bus.any_done = r_any_done;
endmodule

// File: tb/tb_delay_timer_bank.sv
// Self-checking bench for delay_timer_bank: directed scenarios plus random traffic,
// compared every cycle against an expiry-time reference model.
module tb_delay_timer_bank;
  localparam int NUM_CH = 4;
  localparam int DUR_W  = 11;
  localparam int CPM    = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  delay_timer_bank_if #(.NUM_CH(NUM_CH), .DUR_W(DUR_W)) bus ();

  delay_timer_bank #(
    .NUM_CH(NUM_CH), .DUR_W(DUR_W), .CYCLES_PER_MS(CPM)
  ) dut (
    .clock(clk),
    .reset(rst),
    .bus  (bus)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: each running channel holds the absolute cycle of its next expiry.
  bit                m_active [NUM_CH];
  bit                m_per    [NUM_CH];
  longint            m_next   [NUM_CH];
  longint            m_period [NUM_CH];
  logic [NUM_CH-1:0] m_done;
  longint            cyc = 0;
  int                pulses   [NUM_CH];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask

  task automatic clear_pulses();
    for (int c = 0; c < NUM_CH; c++) pulses[c] = 0;
  endtask

  task automatic load(input int c, input int d, input bit p);
    bus.duration[c*DUR_W +: DUR_W] = DUR_W'(d);
    bus.periodic[c] = p;
    bus.start[c]    = 1'b1;
  endtask

  task automatic step();
    logic [NUM_CH-1:0] exp_busy;
    @(posedge clk);
    cyc++;
    m_done = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      longint d;
      d = longint'(bus.duration[c*DUR_W +: DUR_W]);
      if (rst || bus.abort[c]) begin
        m_active[c] = 1'b0;
      end else if (bus.start[c]) begin
        if (d == 0) begin
          m_active[c] = 1'b0;
          m_done[c]   = 1'b1;
        end else begin
          m_active[c] = 1'b1;
          m_per[c]    = bus.periodic[c];
          m_period[c] = d * CPM;
          m_next[c]   = cyc + d * CPM;
        end
      end else if (m_active[c] && cyc == m_next[c]) begin
        m_done[c] = 1'b1;
        if (m_per[c]) m_next[c] = m_next[c] + m_period[c];
        else          m_active[c] = 1'b0;
      end
    end
    #1;
    for (int c = 0; c < NUM_CH; c++) begin
      exp_busy[c] = m_active[c];
      pulses[c]   = pulses[c] + int'(bus.done[c]);
    end
    check("busy",     32'(bus.busy),     32'(exp_busy));
    check("done",     32'(bus.done),     32'(m_done));
    check("any_done", 32'(bus.any_done), 32'(|m_done));
    bus.start = '0;
    bus.abort = '0;
  endtask

  initial begin
    bus.start    = '0;
    bus.abort    = '0;
    bus.periodic = '0;
    bus.duration = '0;
    for (int c = 0; c < NUM_CH; c++) m_active[c] = 1'b0;
    clear_pulses();

    repeat (2) @(posedge clk);
    #1;
    check("reset_busy",     32'(bus.busy),     32'd0);
    check("reset_done",     32'(bus.done),     32'd0);
    check("reset_any_done", 32'(bus.any_done), 32'd0);
    rst = 1'b0;

    // One-shot D=3 on ch0: single pulse 30 cycles after start.
    clear_pulses();
    load(0, 3, 1'b0);
    step();
    check("t1_busy_after_start", 32'(bus.busy[0]), 32'd1);
    repeat (29) step();
    check("t1_no_done_yet", 32'(bus.done[0]), 32'd0);
    step();
    check("t1_done_at_30", 32'(bus.done[0]), 32'd1);
    check("t1_any_done_at_30", 32'(bus.any_done), 32'd1);
    check("t1_busy_low_with_done", 32'(bus.busy[0]), 32'd0);
    repeat (5) step();
    check("t1_pulses", 32'(pulses[0]), 32'd1);

    // Periodic D=2 on ch1, aborted at k+50: pulses at k+20 and k+40 only.
    clear_pulses();
    load(1, 2, 1'b1);
    step();
    repeat (49) step();
    bus.abort[1] = 1'b1;
    step();
    check("t2_busy_after_abort", 32'(bus.busy[1]), 32'd0);
    repeat (30) step();
    check("t2_pulses", 32'(pulses[1]), 32'd2);

    // Retrigger: D=5 then D=1 at k+25 -> expiry at k+35 only.
    clear_pulses();
    load(2, 5, 1'b0);
    step();
    repeat (24) step();
    load(2, 1, 1'b0);
    step();
    repeat (9) step();
    step();
    check("t3_done_at_35", 32'(bus.done[2]), 32'd1);
    repeat (25) step();
    check("t3_pulses", 32'(pulses[2]), 32'd1);

    // D=0 on ch3 pulses next cycle without busy; start+abort on ch0 is ignored.
    clear_pulses();
    load(3, 0, 1'b1);
    step();
    check("t4_d0_done",  32'(bus.done[3]), 32'd1);
    check("t4_d0_busy",  32'(bus.busy[3]), 32'd0);
    load(0, 4, 1'b0);
    bus.abort[0] = 1'b1;
    step();
    check("t4_start_abort_busy", 32'(bus.busy[0]), 32'd0);
    repeat (45) step();
    check("t4_d0_pulses",    32'(pulses[3]), 32'd1);
    check("t4_abort_pulses", 32'(pulses[0]), 32'd0);

    // All channels D=1 on the same edge.
    clear_pulses();
    for (int c = 0; c < NUM_CH; c++) load(c, 1, 1'b0);
    step();
    repeat (9) step();
    step();
    check("t5_all_done", 32'(bus.done), 32'hF);
    step();
    check("t5_any_done_1cycle", 32'(bus.any_done), 32'd0);
    for (int c = 0; c < NUM_CH; c++) check("t5_pulses", 32'(pulses[c]), 32'd1);

    // Repeat as periodic, reset mid-run: outputs clear at once, no pulses afterwards.
    for (int c = 0; c < NUM_CH; c++) load(c, 1, 1'b1);
    step();
    repeat (5) step();
    #2;
    rst = 1'b1;
    #1;
    for (int c = 0; c < NUM_CH; c++) m_active[c] = 1'b0;
    check("t5_rst_busy",     32'(bus.busy),     32'd0);
    check("t5_rst_done",     32'(bus.done),     32'd0);
    check("t5_rst_any_done", 32'(bus.any_done), 32'd0);
    clear_pulses();
    repeat (3) step();
    rst = 1'b0;
    repeat (30) step();
    for (int c = 0; c < NUM_CH; c++) check("t5_post_rst_pulses", 32'(pulses[c]), 32'd0);

    // Random traffic; duration/periodic wiggle every cycle to confirm they only matter at start.
    repeat (500) begin
      bus.duration = '0;
      for (int c = 0; c < NUM_CH; c++) begin
        bus.duration[c*DUR_W +: DUR_W] = DUR_W'($urandom_range(0, 4));
        bus.periodic[c] = 1'($urandom_range(0, 1));
        bus.start[c]    = ($urandom_range(0, 15) == 0);
        bus.abort[c]    = ($urandom_range(0, 39) == 0);
      end
      step();
    end
    bus.abort = '1;
    step();
    repeat (5) step();
    check("final_idle", 32'(bus.busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
